seq_serializer: RTL and testbench

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_serializer_pkg.sv | 13 +
 rtl/seq_serializer_if.sv | 31 +++
 rtl/seq_serializer_word_fifo2.sv | 59 +++++
 rtl/seq_serializer.sv | 114 +++++++++++
 tb/tb_seq_serializer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serializer slice.
//   state_t : FSM encoding (ST_IDLE, ST_SHIFT)
//   COUNT_W : width of the completed-word counter
package seq_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int COUNT_W = 16;

endpackage

// File: rtl/seq_serializer_if.sv
// Parallel-in / serial-out bus bundle for seq_serializer.
//   in_data, in_valid : parallel word offered by the producer
//   in_ready          : serializer can take a word this cycle
//   ser_bit, ser_valid, ser_last : serial stream toward the sequence detector
// Handshake: a word moves when in_valid and in_ready are both high at a
// rising clk edge. in_ready never depends on in_valid in the same cycle, and
// a producer must hold in_data stable while in_valid is high and in_ready low.
// The serial side has no back-pressure: ser_bit is meaningful whenever
// ser_valid is high.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_last;

  // Serializer side
  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_bit, ser_valid, ser_last
  );

  // Producer / observer side
  modport master (
    output in_data, in_valid,
    input  in_ready, ser_bit, ser_valid, ser_last
  );
endinterface

// File: rtl/seq_serializer_word_fifo2.sv
// word_fifo2: two-entry word FIFO feeding the serializer shift register.
//   clk, reset : clock, synchronous active-high reset
//   push, wr_data : write request and data (ignored while full)
//   pop           : read request (ignored while empty)
//   full, empty   : registered occupancy flags
//   head          : oldest stored word, valid while !empty
// Push and pop in the same cycle leave the occupancy unchanged.
module word_fifo2
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
      mem[0]  <= '0;
      mem[1]  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: buffers parallel words in a 2-entry FIFO and shifts them
// out one bit per clock, back-to-back with no gap bit between words.
//   clk, reset : clock, synchronous active-high reset
//   bus        : seq_serializer_if.slave (in_data/in_valid/in_ready in,
//                ser_bit/ser_valid/ser_last out)
//   busy       : a word is shifting or the FIFO holds a word
//   word_count : number of fully serialized words (wraps)
//   state_dbg  : current FSM state
// All outputs come from registers only.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  seq_serializer_if.slave    bus,
  output logic               busy,
  output logic [COUNT_W-1:0] word_count,
  output state_t             state_dbg
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] word_count_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_head;

  word_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.in_valid),
    .wr_data (bus.in_data),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_head;
          cnt_d    = CNT_LOAD;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          // Last bit of the word: chain straight into the next queued word
          // so the serial stream stays contiguous.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_head;
            cnt_d    = CNT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_count_q <= '0;
    end else if (bus.ser_last) begin
      word_count_q <= word_count_q + COUNT_W'(1);
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.ser_valid = (state_q == ST_SHIFT);
  assign bus.ser_last  = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign bus.ser_bit   = (state_q == ST_SHIFT)
                         ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0])
                         : IDLE_BIT;
  assign busy          = (state_q == ST_SHIFT) || !fifo_empty;
  assign word_count    = word_count_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed testbench for seq_serializer.
//   dut0 : WIDTH=8, MSB first, IDLE_BIT=0
//   dut1 : WIDTH=8, LSB first, IDLE_BIT=0
//   dut2 : WIDTH=8, MSB first, IDLE_BIT=1 (kept idle)
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_serializer;
  import seq_serializer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_serializer_if #(.WIDTH(8)) if0 ();
  seq_serializer_if #(.WIDTH(8)) if1 ();
  seq_serializer_if #(.WIDTH(8)) if2 ();

  logic               busy0, busy1, busy2;
  logic [COUNT_W-1:0] wc0, wc1, wc2;
  state_t             st0, st1, st2;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .busy(busy0), .word_count(wc0), .state_dbg(st0)
  );
  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .busy(busy1), .word_count(wc1), .state_dbg(st1)
  );
  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .bus(if2), .busy(busy2), .word_count(wc2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] bb_words [3];
  logic [7:0] sw_exp;
  logic [7:0] lsb_exp;
  logic       acc;
  logic       exp_v, exp_l, exp_b, exp_r;
  logic       saw_last;
  int         nbits;
  int         idx;

  initial begin
    bb_words[0] = 8'hA5;
    bb_words[1] = 8'h3C;
    bb_words[2] = 8'hFF;
    sw_exp      = 8'b0100_1001;   // 8'h49 transmitted MSB first
    lsb_exp     = 8'b0000_0001;   // 8'h01 transmitted LSB first: 1 then seven 0s

    // Reset with a transfer presented on dut0: it must be dropped.
    reset        = 1'b1;
    if0.in_valid = 1'b1;
    if0.in_data  = 8'hAA;
    if1.in_valid = 1'b0;
    if1.in_data  = 8'h00;
    if2.in_valid = 1'b0;
    if2.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  if0.in_ready,  1'b1);
    chk("rst_ser_valid", if0.ser_valid, 1'b0);
    chk("rst_ser_last",  if0.ser_last,  1'b0);
    chk("rst_ser_bit",   if0.ser_bit,   1'b0);
    chk("rst_busy",      busy0,         1'b0);
    chk("rst_wc",        wc0,           16'h0000);
    chk("rst_state",     st0,           ST_IDLE);
    chk("rst_ser_bit_idle1", if2.ser_bit, 1'b1);
    if0.in_valid = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    chk("rst_drop_busy", busy0, 1'b0);
    chk("rst_drop_wc",   wc0,   16'h0000);

    // Idle level on the IDLE_BIT=1 instance.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle1_bit_valid", {30'd0, if2.ser_valid, if2.ser_bit}, 32'h1);
    end

    // Single word 8'h49, MSB first.
    if0.in_data  = 8'h49;
    if0.in_valid = 1'b1;
    @(negedge clk);                   // accepted at this edge (N)
    if0.in_valid = 1'b0;
    chk("sw_not_yet_valid", if0.ser_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("sw_valid", if0.ser_valid, 1'b1);
      chk("sw_bit",   if0.ser_bit,   sw_exp[7-i]);
      chk("sw_last",  if0.ser_last,  (i == 7));
    end
    @(negedge clk);
    chk("sw_after_valid", if0.ser_valid, 1'b0);
    chk("sw_wc",          wc0,           16'd1);
    chk("sw_busy",        busy0,         1'b0);
    chk("sw_state",       st0,           ST_IDLE);

    // LSB first on dut1: 8'h01.
    if1.in_data  = 8'h01;
    if1.in_valid = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lsb_valid", if1.ser_valid, 1'b1);
      chk("lsb_bit",   if1.ser_bit,   lsb_exp[i]);
    end
    @(negedge clk);
    chk("lsb_wc", wc1, 16'd1);

    // Back-to-back: in_valid held high with A5, 3C, FF.
    // Pushes land at E1, E2, E3; bits occupy samples 1..24; in_ready is low
    // for samples 2..8 while the FIFO holds two words.
    idx          = 0;
    if0.in_data  = bb_words[0];
    if0.in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      acc = if0.in_valid && if0.in_ready;
      @(negedge clk);
      exp_v = (c >= 1) && (c <= 24);
      exp_l = exp_v && (((c - 1) % 8) == 7);
      exp_b = exp_v ? bb_words[(c - 1) / 8][7 - ((c - 1) % 8)] : 1'b0;
      exp_r = !((c >= 2) && (c <= 8));
      chk("bb_valid",    if0.ser_valid, exp_v);
      chk("bb_last",     if0.ser_last,  exp_l);
      chk("bb_bit",      if0.ser_bit,   exp_b);
      chk("bb_in_ready", if0.in_ready,  exp_r);
      if (acc) begin
        idx++;
        if (idx < 3) if0.in_data = bb_words[idx];
        else         if0.in_valid = 1'b0;
      end
    end
    chk("bb_wc",   wc0,   16'd4);
    chk("bb_busy", busy0, 1'b0);

    // Wrap: preload the counter to FFFF, then serialize one more word.
    force dut0.word_count_q = 16'hFFFF;
    #1;
    release dut0.word_count_q;
    @(negedge clk);
    chk("wrap_preload", wc0, 16'hFFFF);
    if0.in_data  = 8'h00;
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    saw_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if0.ser_last) begin
        saw_last = 1'b1;
        break;
      end
    end
    chk("wrap_last_seen", saw_last, 1'b1);
    @(negedge clk);
    chk("wrap_wc", wc0, 16'h0000);

    // Reset mid-word: queue two words, reset after bit 3 of the first.
    if0.in_data  = 8'hC3;
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_data  = 8'h5A;
    nbits    = 0;
    saw_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if0.in_valid = 1'b0;
      if (if0.ser_valid) nbits++;
      if (if0.ser_last)  saw_last = 1'b1;
      if (nbits == 3) break;
    end
    chk("mid_bits_before_reset", nbits, 3);
    chk("mid_bit3_value",        if0.ser_bit, 1'b0);   // C3 = 1100_0011, third bit 0
    reset        = 1'b1;
    if0.in_data  = 8'hFF;                              // presented during reset
    if0.in_valid = 1'b1;
    @(negedge clk);
    chk("mid_ser_valid", if0.ser_valid, 1'b0);
    chk("mid_in_ready",  if0.in_ready,  1'b1);
    chk("mid_busy",      busy0,         1'b0);
    chk("mid_wc",        wc0,           16'h0000);
    reset        = 1'b0;
    if0.in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if0.ser_last) saw_last = 1'b1;
      chk("post_rst_valid", if0.ser_valid, 1'b0);
      chk("post_rst_busy",  busy0,         1'b0);
    end
    chk("mid_no_last", saw_last, 1'b0);
    chk("post_rst_wc", wc0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
